instruction_decode_stage: RTL and testbench
===========================================

Name: instruction_decode_stage

Overview:
- Decode stage of the pipelined processor, the producer side of the execute-stage interface.
- Decodes a 20-bit instruction and reads a register file.
- Tracks pending register writes with a scoreboard and loads the ID/EX pipeline register.
- The ID/EX register drives the ALU signals `control`, `opA` and `rfReadData2`; the writeback stage returns results through a write port.

Parameters:
- DATA_WIDTH, 20, width of registers and operands.
- REG_ADDR_WIDTH, 3, register index width; register file holds 2**REG_ADDR_WIDTH entries.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- inValid  in  1  instruction valid from fetch.
- instruction  in  20  [19:16] opcode, [15:13] rd, [12:10] rs, [9:7] rt, [6:0] unused.
- idReady  out  1  decode accepts the instruction this cycle; fetch holds when 0.
- stall  in  1  external stall from the hazard unit.
- flush  in  1  discard the current instruction (taken branch).
- wbEnable  in  1  writeback write enable.
- wbAddr  in  3  writeback register index.
- wbData  in  20  writeback data.
- exValid  out  1  ID/EX holds a real instruction.
- exControl  out  2  ALU control: 00 add, 01 or, 10 and, 11 not.
- exOpA  out  20  register file value of rs.
- exOpB  out  20  register file value of rt (drives rfReadData2).
- exRd  out  3  destination register.
- exRegWrite  out  1  instruction writes rd.
- exBranch  out  1  instruction is beq (taken when the ALU reports equality).
- illegalFlag  out  1  sticky flag: an unknown opcode was accepted.

Behaviour:
- Reset (reset=0, async) clears:
  - all ID/EX outputs to 0;
  - all registers to 0;
  - all scoreboard bits to 0;
  - illegalFlag to 0.
- Opcode decode:
  - 0000 add: control 00, regWrite 1.
  - 0001 or: control 01, regWrite 1.
  - 0010 and: control 10, regWrite 1.
  - 0011 not: control 11, regWrite 1; rt is ignored for hazards.
  - 0100 beq: control 00, regWrite 0, branch 1.
  - 1111 nop: regWrite 0.
  - Any other opcode behaves as nop and sets illegalFlag when accepted.
- Register file:
  - Two combinational read ports (rs, rt), one write port.
  - Register 0 always reads 0; writes to register 0 are ignored.
  - Write bypass: when wbEnable=1 and wbAddr equals a read index (not 0), the read returns wbData in the same cycle. The register is written at the clock edge.
- Scoreboard (one pending bit per register):
  - Set at acceptance of an instruction with regWrite=1 and rd≠0.
  - Cleared when wbEnable=1 with that wbAddr.
  - Set and clear of the same bit in the same cycle: set wins.
- Hazard:
  - hazard=1 when inValid=1 and a source register is pending and not being cleared this cycle.
  - Sources checked: rs; rt except for `not`; register 0 is never a hazard.
- Priority per cycle:
  - flush=1:
    - ID/EX loads a bubble (exValid, exRegWrite and exBranch all 0).
    - idReady=1, so the instruction is dropped.
    - No scoreboard set; illegalFlag unchanged.
  - else stall=1 or hazard=1: ID/EX loads a bubble, idReady=0.
  - else inValid=1: ID/EX loads the decoded instruction with exValid=1, idReady=1, and the scoreboard updates.
  - else: bubble, idReady=1.
- Latency: an instruction accepted at edge N appears on the ex* outputs after edge N (one cycle).
- Bubble content: exControl, exOpA, exOpB and exRd are 0.
- idReady is combinational.
- Reset asserted mid-stream discards the ID/EX contents and all pending bits immediately.

Test Plan:
- Reset, then wb writes r1=5 and r2=3; issue add r3,r1,r2 → next cycle exValid=1, exControl=00, exOpA=5, exOpB=3, exRd=3, exRegWrite=1.
- Bypass: wbEnable with r4=20'hABCDE in the same cycle as decode of or r5,r4,r0 → exOpA=20'hABCDE, exOpB=0, no stall.
- RAW: add r3,r1,r2 then and r6,r3,r1 → idReady=0 and bubbles until a wb to r3 is presented; the `and` issues in that cycle with exOpA=wbData.
- flush=1 together with stall=1 and a valid beq → bubble, idReady=1, no scoreboard bit set, exBranch stays 0.
- Opcode 0111 accepted → treated as nop (exRegWrite=0, exValid=1); illegalFlag=1 and stays 1 until reset.
- Assert reset while r3 is pending and ID/EX is valid → all ex* outputs 0 asynchronously; after release, a reader of r3 issues without stall and reads 0.

Source files
------------

// File: rtl/instruction_decode_stage_if.sv
// Decode-stage bundle: fetch handshake, hazard controls, writeback port
// and the ID/EX outputs that feed the execute stage.
interface instruction_decode_stage_if #(
    parameter int DATA_WIDTH     = 20,
    parameter int REG_ADDR_WIDTH = 3
);
    logic                      inValid;
    logic [19:0]               instruction;
    logic                      idReady;
    logic                      stall;
    logic                      flush;
    logic                      wbEnable;
    logic [REG_ADDR_WIDTH-1:0] wbAddr;
    logic [DATA_WIDTH-1:0]     wbData;
    logic                      exValid;
    logic [1:0]                exControl;
    logic [DATA_WIDTH-1:0]     exOpA;
    logic [DATA_WIDTH-1:0]     exOpB;
    logic [REG_ADDR_WIDTH-1:0] exRd;
    logic                      exRegWrite;
    logic                      exBranch;
    logic                      illegalFlag;

    // Decode stage side: consumes fetch/writeback, produces ID/EX.
    modport master (
        input  inValid, instruction, stall, flush, wbEnable, wbAddr, wbData,
        output idReady, exValid, exControl, exOpA, exOpB, exRd,
               exRegWrite, exBranch, illegalFlag
    );

    // Environment side: fetch, hazard unit, writeback and execute.
    modport slave (
        output inValid, instruction, stall, flush, wbEnable, wbAddr, wbData,
        input  idReady, exValid, exControl, exOpA, exOpB, exRd,
               exRegWrite, exBranch, illegalFlag
    );
endinterface

// File: rtl/instruction_decode_stage.sv
// Instruction decode stage: opcode decode, 2R/1W register file with
// writeback bypass, pending-write scoreboard, hazard detection and the
// ID/EX pipeline register.
module instruction_decode_stage #(
    parameter int DATA_WIDTH     = 20,
    parameter int REG_ADDR_WIDTH = 3
) (
    input  logic                         clock,
    input  logic                         reset,
    instruction_decode_stage_if.master   bus
);
    localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;

    typedef enum logic [3:0] {
        OP_ADD = 4'b0000,
        OP_OR  = 4'b0001,
        OP_AND = 4'b0010,
        OP_NOT = 4'b0011,
        OP_BEQ = 4'b0100,
        OP_NOP = 4'b1111
    } opcode_e;

    // Instruction fields
    logic [3:0]                opcode_s;
    logic [REG_ADDR_WIDTH-1:0] rd_s;
    logic [REG_ADDR_WIDTH-1:0] rs_s;
    logic [REG_ADDR_WIDTH-1:0] rt_s;

    assign opcode_s = bus.instruction[19:16];
    assign rd_s     = bus.instruction[15:13];
    assign rs_s     = bus.instruction[12:10];
    assign rt_s     = bus.instruction[9:7];

    // State
    logic [DATA_WIDTH-1:0]     rf_q [NUM_REGS];
    logic [NUM_REGS-1:0]       sb_q;
    logic [NUM_REGS-1:0]       sb_d;
    logic                      illegal_q;
    logic                      illegal_d;

    logic                      ex_valid_q,     ex_valid_d;
    logic [1:0]                ex_control_q,   ex_control_d;
    logic [DATA_WIDTH-1:0]     ex_opa_q,       ex_opa_d;
    logic [DATA_WIDTH-1:0]     ex_opb_q,       ex_opb_d;
    logic [REG_ADDR_WIDTH-1:0] ex_rd_q,        ex_rd_d;
    logic                      ex_reg_write_q, ex_reg_write_d;
    logic                      ex_branch_q,    ex_branch_d;

    // Decoded controls
    logic [1:0]                ctrl_s;
    logic                      reg_write_s;
    logic                      branch_s;
    logic                      uses_rt_s;
    logic                      illegal_s;

    logic [DATA_WIDTH-1:0]     rs_data_s;
    logic [DATA_WIDTH-1:0]     rt_data_s;
    logic                      rs_hazard_s;
    logic                      rt_hazard_s;
    logic                      hazard_s;
    logic                      accept_s;
    logic                      id_ready_s;

    // Opcode decode; unknown opcodes behave as nop and are flagged
    always_comb begin
        ctrl_s      = 2'b00;
        reg_write_s = 1'b0;
        branch_s    = 1'b0;
        uses_rt_s   = 1'b1;
        illegal_s   = 1'b0;
        case (opcode_s)
            OP_ADD: begin ctrl_s = 2'b00; reg_write_s = 1'b1; end
            OP_OR:  begin ctrl_s = 2'b01; reg_write_s = 1'b1; end
            OP_AND: begin ctrl_s = 2'b10; reg_write_s = 1'b1; end
            OP_NOT: begin ctrl_s = 2'b11; reg_write_s = 1'b1; uses_rt_s = 1'b0; end
            OP_BEQ: begin ctrl_s = 2'b00; branch_s = 1'b1; end
            OP_NOP: begin ctrl_s = 2'b00; end
            default: begin illegal_s = 1'b1; end
        endcase
    end

    // Read ports: r0 reads zero, a same-cycle writeback to the index is bypassed
    always_comb begin
        rs_data_s = '0;
        rt_data_s = '0;
        if (rs_s == '0) begin
            rs_data_s = '0;
        end else if (bus.wbEnable && (bus.wbAddr == rs_s)) begin
            rs_data_s = bus.wbData;
        end else begin
            rs_data_s = rf_q[rs_s];
        end
        if (rt_s == '0) begin
            rt_data_s = '0;
        end else if (bus.wbEnable && (bus.wbAddr == rt_s)) begin
            rt_data_s = bus.wbData;
        end else begin
            rt_data_s = rf_q[rt_s];
        end
    end

    // Hazard: a source is pending and is not being written back this cycle
    always_comb begin
        rs_hazard_s = (rs_s != '0) && sb_q[rs_s] &&
                      !(bus.wbEnable && (bus.wbAddr == rs_s));
        rt_hazard_s = uses_rt_s && (rt_s != '0) && sb_q[rt_s] &&
                      !(bus.wbEnable && (bus.wbAddr == rt_s));
        hazard_s    = bus.inValid && (rs_hazard_s || rt_hazard_s);
    end

    // Acceptance and ready: flush drops the instruction, stall/hazard hold fetch
    always_comb begin
        accept_s   = 1'b0;
        id_ready_s = 1'b1;
        if (bus.flush) begin
            id_ready_s = 1'b1;
        end else if (bus.stall || hazard_s) begin
            id_ready_s = 1'b0;
        end else begin
            accept_s   = bus.inValid;
            id_ready_s = 1'b1;
        end
    end

    // ID/EX next value: decoded instruction when accepted, otherwise an all-zero bubble
    always_comb begin
        ex_valid_d     = 1'b0;
        ex_control_d   = 2'b00;
        ex_opa_d       = '0;
        ex_opb_d       = '0;
        ex_rd_d        = '0;
        ex_reg_write_d = 1'b0;
        ex_branch_d    = 1'b0;
        if (accept_s) begin
            ex_valid_d     = 1'b1;
            ex_control_d   = ctrl_s;
            ex_opa_d       = rs_data_s;
            ex_opb_d       = rt_data_s;
            ex_rd_d        = rd_s;
            ex_reg_write_d = reg_write_s;
            ex_branch_d    = branch_s;
        end else begin
            ex_valid_d     = 1'b0;
        end
    end

    // Scoreboard and sticky illegal flag; a set overrides a same-cycle clear
    always_comb begin
        sb_d      = sb_q;
        illegal_d = illegal_q;
        if (bus.wbEnable) begin
            sb_d[bus.wbAddr] = 1'b0;
        end else begin
            sb_d = sb_q;
        end
        if (accept_s && reg_write_s && (rd_s != '0)) begin
            sb_d[rd_s] = 1'b1;
        end else begin
            sb_d[0] = 1'b0;
        end
        if (accept_s && illegal_s) begin
            illegal_d = 1'b1;
        end else begin
            illegal_d = illegal_q;
        end
    end

    // Pipeline register, scoreboard and flag state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ex_valid_q     <= 1'b0;
            ex_control_q   <= 2'b00;
            ex_opa_q       <= '0;
            ex_opb_q       <= '0;
            ex_rd_q        <= '0;
            ex_reg_write_q <= 1'b0;
            ex_branch_q    <= 1'b0;
            sb_q           <= '0;
            illegal_q      <= 1'b0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_control_q   <= ex_control_d;
            ex_opa_q       <= ex_opa_d;
            ex_opb_q       <= ex_opb_d;
            ex_rd_q        <= ex_rd_d;
            ex_reg_write_q <= ex_reg_write_d;
            ex_branch_q    <= ex_branch_d;
            sb_q           <= sb_d;
            illegal_q      <= illegal_d;
        end
    end

    // Register file write port; register 0 is never written
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_q[i] <= '0;
            end
        end else if (bus.wbEnable && (bus.wbAddr != '0)) begin
            rf_q[bus.wbAddr] <= bus.wbData;
        end
    end

    assign bus.idReady     = id_ready_s;
    assign bus.exValid     = ex_valid_q;
    assign bus.exControl   = ex_control_q;
    assign bus.exOpA       = ex_opa_q;
    assign bus.exOpB       = ex_opb_q;
    assign bus.exRd        = ex_rd_q;
    assign bus.exRegWrite  = ex_reg_write_q;
    assign bus.exBranch    = ex_branch_q;
    assign bus.illegalFlag = illegal_q;

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Directed bench for instruction_decode_stage: basic issue, bypass, RAW
// hazard, flush/stall priority, illegal opcode and mid-stream reset.
module tb_instruction_decode_stage;
    logic clock;
    logic reset;
    int   tests_run;
    int   tests_failed;

    instruction_decode_stage_if #(.DATA_WIDTH(20), .REG_ADDR_WIDTH(3)) bus ();

    instruction_decode_stage #(.DATA_WIDTH(20), .REG_ADDR_WIDTH(3)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, period 10
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] mk(input logic [3:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs, input logic [2:0] rt);
        return {op, rd, rs, rt, 7'd0};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset           = 1'b0;
        bus.inValid     = 1'b0;
        bus.instruction = 20'd0;
        bus.stall       = 1'b0;
        bus.flush       = 1'b0;
        bus.wbEnable    = 1'b0;
        bus.wbAddr      = 3'd0;
        bus.wbData      = 20'd0;

        #12;
        check_val("rst_exValid", 32'(bus.exValid), 32'd0);
        check_val("rst_exOpA", 32'(bus.exOpA), 32'd0);
        check_val("rst_illegal", 32'(bus.illegalFlag), 32'd0);
        check_val("rst_idReady", 32'(bus.idReady), 32'd1);
        @(negedge clock);
        reset = 1'b1;

        // Write r1=5, r2=3
        bus.wbEnable = 1'b1; bus.wbAddr = 3'd1; bus.wbData = 20'd5;
        tick();
        bus.wbAddr = 3'd2; bus.wbData = 20'd3;
        tick();

        // add r3,r1,r2
        bus.wbEnable = 1'b0;
        bus.inValid = 1'b1; bus.instruction = mk(4'b0000, 3'd3, 3'd1, 3'd2);
        #1 check_val("add_ready", 32'(bus.idReady), 32'd1);
        tick();
        check_val("add_valid", 32'(bus.exValid), 32'd1);
        check_val("add_ctrl", 32'(bus.exControl), 32'd0);
        check_val("add_opA", 32'(bus.exOpA), 32'd5);
        check_val("add_opB", 32'(bus.exOpB), 32'd3);
        check_val("add_rd", 32'(bus.exRd), 32'd3);
        check_val("add_regw", 32'(bus.exRegWrite), 32'd1);

        // and r6,r3,r1: RAW on r3
        bus.instruction = mk(4'b0010, 3'd6, 3'd3, 3'd1);
        #1 check_val("raw_ready0", 32'(bus.idReady), 32'd0);
        tick();
        check_val("raw_bubble_valid", 32'(bus.exValid), 32'd0);
        check_val("raw_bubble_rd", 32'(bus.exRd), 32'd0);
        check_val("raw_ready1", 32'(bus.idReady), 32'd0);
        tick();
        check_val("raw_bubble2", 32'(bus.exValid), 32'd0);
        bus.wbEnable = 1'b1; bus.wbAddr = 3'd3; bus.wbData = 20'h00042;
        #1 check_val("raw_wb_ready", 32'(bus.idReady), 32'd1);
        tick();
        check_val("raw_valid", 32'(bus.exValid), 32'd1);
        check_val("raw_ctrl", 32'(bus.exControl), 32'd2);
        check_val("raw_opA", 32'(bus.exOpA), 32'h42);
        check_val("raw_opB", 32'(bus.exOpB), 32'd5);
        check_val("raw_rd", 32'(bus.exRd), 32'd6);

        // Bypass: wb r4 with or r5,r4,r0
        bus.wbAddr = 3'd4; bus.wbData = 20'hABCDE;
        bus.instruction = mk(4'b0001, 3'd5, 3'd4, 3'd0);
        #1 check_val("byp_ready", 32'(bus.idReady), 32'd1);
        tick();
        check_val("byp_opA", 32'(bus.exOpA), 32'hABCDE);
        check_val("byp_opB", 32'(bus.exOpB), 32'd0);
        check_val("byp_ctrl", 32'(bus.exControl), 32'd1);
        check_val("byp_rd", 32'(bus.exRd), 32'd5);

        // Writeback to r0 must not bypass
        bus.wbAddr = 3'd0; bus.wbData = 20'hFFFFF;
        bus.instruction = mk(4'b0001, 3'd0, 3'd0, 3'd0);
        tick();
        check_val("r0_opA", 32'(bus.exOpA), 32'd0);
        check_val("r0_opB", 32'(bus.exOpB), 32'd0);

        // not r7,r1,r6: rt (pending r6) ignored
        bus.wbEnable = 1'b0;
        bus.instruction = mk(4'b0011, 3'd7, 3'd1, 3'd6);
        #1 check_val("not_ready", 32'(bus.idReady), 32'd1);
        tick();
        check_val("not_ctrl", 32'(bus.exControl), 32'd3);
        check_val("not_opA", 32'(bus.exOpA), 32'd5);

        // add r4,r1,r6: rt hazard
        bus.instruction = mk(4'b0000, 3'd4, 3'd1, 3'd6);
        #1 check_val("rt_haz_ready", 32'(bus.idReady), 32'd0);
        tick();
        check_val("rt_haz_valid", 32'(bus.exValid), 32'd0);

        // flush + stall + beq
        bus.flush = 1'b1; bus.stall = 1'b1;
        bus.instruction = mk(4'b0100, 3'd0, 3'd1, 3'd2);
        #1 check_val("flush_ready", 32'(bus.idReady), 32'd1);
        tick();
        check_val("flush_valid", 32'(bus.exValid), 32'd0);
        check_val("flush_branch", 32'(bus.exBranch), 32'd0);

        // flushed add r1 must not mark r1 pending
        bus.stall = 1'b0;
        bus.instruction = mk(4'b0000, 3'd1, 3'd2, 3'd2);
        tick();
        check_val("flush2_valid", 32'(bus.exValid), 32'd0);
        bus.flush = 1'b0;
        bus.instruction = mk(4'b0000, 3'd4, 3'd1, 3'd1);
        #1 check_val("noset_ready", 32'(bus.idReady), 32'd1);
        tick();
        check_val("noset_valid", 32'(bus.exValid), 32'd1);
        check_val("noset_opA", 32'(bus.exOpA), 32'd5);

        // External stall then beq issue
        bus.stall = 1'b1;
        bus.instruction = mk(4'b0100, 3'd0, 3'd1, 3'd2);
        #1 check_val("stall_ready", 32'(bus.idReady), 32'd0);
        tick();
        check_val("stall_valid", 32'(bus.exValid), 32'd0);
        bus.stall = 1'b0;
        tick();
        check_val("beq_branch", 32'(bus.exBranch), 32'd1);
        check_val("beq_regw", 32'(bus.exRegWrite), 32'd0);
        check_val("beq_opB", 32'(bus.exOpB), 32'd3);
        check_val("pre_illegal", 32'(bus.illegalFlag), 32'd0);

        // Illegal opcode 0111
        bus.instruction = mk(4'b0111, 3'd2, 3'd1, 3'd2);
        tick();
        check_val("ill_valid", 32'(bus.exValid), 32'd1);
        check_val("ill_regw", 32'(bus.exRegWrite), 32'd0);
        check_val("ill_flag", 32'(bus.illegalFlag), 32'd1);
        bus.inValid = 1'b0;
        tick();
        check_val("ill_sticky", 32'(bus.illegalFlag), 32'd1);
        check_val("idle_valid", 32'(bus.exValid), 32'd0);

        // add r3,r2,r2: r2 not pending after the illegal op
        bus.inValid = 1'b1;
        bus.instruction = mk(4'b0000, 3'd3, 3'd2, 3'd2);
        #1 check_val("ill_nosb_ready", 32'(bus.idReady), 32'd1);
        tick();
        check_val("pre_rst_valid", 32'(bus.exValid), 32'd1);
        check_val("pre_rst_opA", 32'(bus.exOpA), 32'd3);

        // Asynchronous reset mid-stream
        bus.inValid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check_val("arst_valid", 32'(bus.exValid), 32'd0);
        check_val("arst_opA", 32'(bus.exOpA), 32'd0);
        check_val("arst_rd", 32'(bus.exRd), 32'd0);
        check_val("arst_regw", 32'(bus.exRegWrite), 32'd0);
        check_val("arst_illegal", 32'(bus.illegalFlag), 32'd0);
        #3 reset = 1'b1;
        bus.inValid = 1'b1;
        bus.instruction = mk(4'b0000, 3'd1, 3'd3, 3'd3);
        #1 check_val("post_rst_ready", 32'(bus.idReady), 32'd1);
        tick();
        check_val("post_rst_valid", 32'(bus.exValid), 32'd1);
        check_val("post_rst_opA", 32'(bus.exOpA), 32'd0);
        check_val("post_rst_opB", 32'(bus.exOpB), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
